// File: rtl/z3_slave_decode_pkg.sv
// Shared definitions for the Zorro III slave-cycle front end:
// state encoding, region offsets and region vector layout.
package z3_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_ACKED,
    ST_IGNORE
  } z3_state_e;

  // ADDR[23:18] offsets inside the BAR
  localparam logic [5:0] REG_SCSI_LO = 6'h20;
  localparam logic [5:0] REG_SCSI_HI = 6'h21;
  localparam logic [5:0] REG_IDREG   = 6'h22;
  localparam logic [5:0] REG_SID     = 6'h23;

  localparam logic [7:0] AUTOCFG_BASE_DEF = 8'hFF;

  localparam int RGN_SCSI    = 0;
  localparam int RGN_IDREG   = 1;
  localparam int RGN_SID     = 2;
  localparam int RGN_AUTOCFG = 3;
  localparam int NUM_RGN     = 4;

  typedef logic [NUM_RGN-1:0] region_t;

endpackage

// File: rtl/z3_slave_decode_if.sv
// Bus-side and responder-side signals of the slave-cycle front end.
interface z3_slave_decode_if;
  logic        FCS_n;
  logic [15:0] ADDR;
  logic        READ;
  logic        configured;
  logic [7:0]  bar_base;
  logic        scsi_dtack;
  logic        idreg_dtack;
  logic        sid_dtack;
  logic        autocfg_dtack;
  logic        slave_cycle;
  logic        scsi_region;
  logic        idreg_region;
  logic        sidreg_region;
  logic        autocfg_region;
  logic        read_l;
  logic        dtack;
  logic        timeout_flag;

  modport slave (
    input  FCS_n, ADDR, READ, configured, bar_base,
           scsi_dtack, idreg_dtack, sid_dtack, autocfg_dtack,
    output slave_cycle, scsi_region, idreg_region, sidreg_region,
           autocfg_region, read_l, dtack, timeout_flag
  );

  modport master (
    output FCS_n, ADDR, READ, configured, bar_base,
           scsi_dtack, idreg_dtack, sid_dtack, autocfg_dtack,
    input  slave_cycle, scsi_region, idreg_region, sidreg_region,
           autocfg_region, read_l, dtack, timeout_flag
  );
endinterface

// File: rtl/z3_region_decode.sv
// Combinational ADDR[31:16] compare producing the one-hot region vector.
module z3_region_decode
  import z3_pkg::*;
#(
  parameter logic [7:0] AUTOCFG_BASE = AUTOCFG_BASE_DEF
) (
  input  logic [15:0] addr,
  input  logic        configured,
  input  logic [7:0]  bar_base,
  output region_t     region
);

  always_comb begin
    region = '0;
    if (!configured && addr[15:8] == AUTOCFG_BASE) begin
      region[RGN_AUTOCFG] = 1'b1;
    end else if (configured && addr[15:8] == bar_base) begin
      // addr[7:0] is ADDR[23:16]; the low two bits are don't-care inside a region
      if (addr[7:0] inside {[{REG_SCSI_LO, 2'b00} : {REG_SCSI_HI, 2'b11}]})
        region[RGN_SCSI] = 1'b1;
      else if (addr[7:0] inside {[{REG_IDREG, 2'b00} : {REG_IDREG, 2'b11}]})
        region[RGN_IDREG] = 1'b1;
      else if (addr[7:0] inside {[{REG_SID, 2'b00} : {REG_SID, 2'b11}]})
        region[RGN_SID] = 1'b1;
    end
  end

endmodule

// File: rtl/z3_slave_decode.sv
// Zorro III slave-cycle front end: latches the decode on FCS_n, merges
// responder DTACKs and forces termination if the selected responder stays silent.
module z3_slave_decode
  import z3_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [7:0]  AUTOCFG_BASE   = AUTOCFG_BASE_DEF
) (
  input  logic           CLK,
  input  logic           RESET_n,
  z3_slave_decode_if.slave bus
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  z3_state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  region_t    region_q, region_d, region_dec, ack_req;
  logic       slave_q, slave_d;
  logic       read_q, read_d;
  logic       dtack_q, dtack_d;
  logic       tf_q, tf_d;
  logic       sel_ack;

  z3_region_decode #(.AUTOCFG_BASE(AUTOCFG_BASE)) u_dec (
    .addr       (bus.ADDR),
    .configured (bus.configured),
    .bar_base   (bus.bar_base),
    .region     (region_dec)
  );

  always_comb begin
    ack_req = '0;
    ack_req[RGN_SCSI]    = bus.scsi_dtack;
    ack_req[RGN_IDREG]   = bus.idreg_dtack;
    ack_req[RGN_SID]     = bus.sid_dtack;
    ack_req[RGN_AUTOCFG] = bus.autocfg_dtack;
  end

  // only the latched region's responder can terminate the cycle
  assign sel_ack = |(region_q & ack_req);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    region_d = region_q;
    slave_d  = slave_q;
    read_d   = read_q;
    dtack_d  = dtack_q;
    tf_d     = tf_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!bus.FCS_n) begin
          region_d = region_dec;
          read_d   = bus.READ;
          cnt_d    = '0;
          if (|region_dec) begin
            slave_d = 1'b1;
            state_d = ST_ACTIVE;
          end else begin
            state_d = ST_IGNORE;
          end
        end
      end
      ST_ACTIVE: begin
        // abort outranks a same-edge ack, and an ack outranks the timeout
        if (bus.FCS_n) begin
          region_d = '0;
          slave_d  = 1'b0;
          state_d  = ST_IDLE;
        end else if (sel_ack) begin
          dtack_d = 1'b1;
          state_d = ST_ACKED;
        end else if (cnt_q == TO_LAST) begin
          dtack_d = 1'b1;
          tf_d    = 1'b1;
          state_d = ST_ACKED;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_ACKED: begin
        if (bus.FCS_n) begin
          dtack_d  = 1'b0;
          slave_d  = 1'b0;
          region_d = '0;
          state_d  = ST_IDLE;
        end
      end
      ST_IGNORE: begin
        if (bus.FCS_n) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      region_q <= '0;
      slave_q  <= 1'b0;
      read_q   <= 1'b0;
      dtack_q  <= 1'b0;
      tf_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      region_q <= region_d;
      slave_q  <= slave_d;
      read_q   <= read_d;
      dtack_q  <= dtack_d;
      tf_q     <= tf_d;
    end
  end

  assign bus.slave_cycle    = slave_q;
  assign bus.scsi_region    = region_q[RGN_SCSI];
  assign bus.idreg_region   = region_q[RGN_IDREG];
  assign bus.sidreg_region  = region_q[RGN_SID];
  assign bus.autocfg_region = region_q[RGN_AUTOCFG];
  assign bus.read_l         = read_q;
  assign bus.dtack          = dtack_q;
  assign bus.timeout_flag   = tf_q;

endmodule

// File: tb/tb_z3_slave_decode.sv
// Scoreboard bench for z3_slave_decode: per-cycle expected output words are
// queued with the stimulus and popped one cycle later for comparison.
module tb_z3_slave_decode;

  logic CLK = 1'b0;
  logic RESET_n;
  int   checks = 0;
  int   errors = 0;

  string      tq[$];
  logic [7:0] eq[$];

  z3_slave_decode_if bus ();

  z3_slave_decode #(.TIMEOUT_CYCLES(64), .AUTOCFG_BASE(8'hFF)) dut (
    .CLK     (CLK),
    .RESET_n (RESET_n),
    .bus     (bus)
  );

  always #5 CLK = ~CLK;

  // {slave_cycle, autocfg, sid, idreg, scsi, read_l, dtack, timeout_flag}
  logic [7:0] o;
  assign o = {bus.slave_cycle, bus.autocfg_region, bus.sidreg_region, bus.idreg_region,
              bus.scsi_region, bus.read_l, bus.dtack, bus.timeout_flag};

  function automatic logic [7:0] ov(input logic sc, input logic [3:0] rg,
                                    input logic rl, input logic dt, input logic tf);
    return {sc, rg, rl, dt, tf};
  endfunction

  task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b", tag, act, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic [7:0] e);
    string      t;
    logic [7:0] x;
    tq.push_back(tag);
    eq.push_back(e);
    @(posedge CLK);
    #1;
    t = tq.pop_front();
    x = eq.pop_front();
    chk(t, o, x);
  endtask

  task automatic cycn(input string tag, input int n, input logic [7:0] e);
    for (int i = 0; i < n; i++) cyc(tag, e);
  endtask

  localparam logic [3:0] R_NONE = 4'b0000, R_AUTO = 4'b1000, R_SID = 4'b0100,
                         R_IDR  = 4'b0010, R_SCSI = 4'b0001;

  initial begin
    RESET_n = 1'b0;
    bus.FCS_n = 1'b1; bus.ADDR = 16'h0000; bus.READ = 1'b0;
    bus.configured = 1'b0; bus.bar_base = 8'h00;
    bus.scsi_dtack = 1'b0; bus.idreg_dtack = 1'b0;
    bus.sid_dtack = 1'b0; bus.autocfg_dtack = 1'b0;
    #12;
    chk("reset", o, 8'h00);
    RESET_n = 1'b1;

    // SID read acked by responder
    bus.configured = 1'b1; bus.bar_base = 8'h40;
    bus.ADDR = 16'h408C; bus.READ = 1'b1; bus.FCS_n = 1'b0;
    cyc("sid_dec", ov(1, R_SID, 1, 0, 0));
    bus.READ = 1'b0;
    cycn("sid_wait", 2, ov(1, R_SID, 1, 0, 0));
    bus.sid_dtack = 1'b1;
    cyc("sid_ack", ov(1, R_SID, 1, 1, 0));
    bus.sid_dtack = 1'b0;
    cyc("sid_hold", ov(1, R_SID, 1, 1, 0));
    bus.FCS_n = 1'b1;
    cyc("sid_end", ov(0, R_NONE, 1, 0, 0));

    // autoconfig while unconfigured
    bus.configured = 1'b0; bus.ADDR = 16'hFF00; bus.READ = 1'b0; bus.FCS_n = 1'b0;
    cyc("acfg_dec", ov(1, R_AUTO, 0, 0, 0));
    bus.autocfg_dtack = 1'b1;
    cyc("acfg_ack", ov(1, R_AUTO, 0, 1, 0));
    bus.autocfg_dtack = 1'b0; bus.FCS_n = 1'b1;
    cyc("acfg_end", ov(0, R_NONE, 0, 0, 0));

    // same address once configured: ignored, responder acks have no effect
    bus.configured = 1'b1; bus.READ = 1'b1; bus.FCS_n = 1'b0;
    cyc("ign_dec", ov(0, R_NONE, 1, 0, 0));
    bus.autocfg_dtack = 1'b1; bus.scsi_dtack = 1'b1;
    cycn("ign_hold", 3, ov(0, R_NONE, 1, 0, 0));
    bus.autocfg_dtack = 1'b0; bus.scsi_dtack = 1'b0; bus.FCS_n = 1'b1;
    cyc("ign_end", ov(0, R_NONE, 1, 0, 0));

    // idreg with silent responder: forced termination on the 64th ACTIVE edge
    bus.ADDR = 16'h4088; bus.READ = 1'b0; bus.FCS_n = 1'b0;
    cyc("to_dec", ov(1, R_IDR, 0, 0, 0));
    cycn("to_wait", 63, ov(1, R_IDR, 0, 0, 0));
    cyc("to_fire", ov(1, R_IDR, 0, 1, 1));
    bus.FCS_n = 1'b1;
    cyc("to_end", ov(0, R_NONE, 0, 0, 1));
    cyc("to_sticky", ov(0, R_NONE, 0, 0, 1));

    // scsi: ack and FCS_n rising on the same edge -> abort wins
    bus.ADDR = 16'h4080; bus.READ = 1'b1; bus.FCS_n = 1'b0;
    cyc("abt_dec", ov(1, R_SCSI, 1, 0, 1));
    cyc("abt_wait", ov(1, R_SCSI, 1, 0, 1));
    bus.scsi_dtack = 1'b1; bus.FCS_n = 1'b1;
    cyc("abt_end", ov(0, R_NONE, 1, 0, 1));
    bus.scsi_dtack = 1'b0;
    cyc("abt_idle", ov(0, R_NONE, 1, 0, 1));

    // scsi selected, wrong responder acks -> timeout path
    bus.FCS_n = 1'b0;
    cyc("wr_dec", ov(1, R_SCSI, 1, 0, 1));
    bus.sid_dtack = 1'b1; bus.idreg_dtack = 1'b1;
    cycn("wr_wait", 63, ov(1, R_SCSI, 1, 0, 1));
    cyc("wr_fire", ov(1, R_SCSI, 1, 1, 1));
    bus.sid_dtack = 1'b0; bus.idreg_dtack = 1'b0; bus.FCS_n = 1'b1;
    cyc("wr_end", ov(0, R_NONE, 1, 0, 1));

    // asynchronous reset while ACKED
    bus.ADDR = 16'h408C; bus.READ = 1'b1; bus.FCS_n = 1'b0;
    cyc("ra_dec", ov(1, R_SID, 1, 0, 1));
    bus.sid_dtack = 1'b1;
    cyc("ra_ack", ov(1, R_SID, 1, 1, 1));
    bus.sid_dtack = 1'b0;
    #2 RESET_n = 1'b0;
    #1 chk("ra_async", o, 8'h00);
    #1 RESET_n = 1'b1;
    bus.FCS_n = 1'b1;
    cyc("ra_idle", 8'h00);

    // decodes normally after reset; ack on the timeout edge is a normal ack
    bus.ADDR = 16'h408C; bus.READ = 1'b0; bus.FCS_n = 1'b0;
    cyc("ta_dec", ov(1, R_SID, 0, 0, 0));
    cycn("ta_wait", 63, ov(1, R_SID, 0, 0, 0));
    bus.sid_dtack = 1'b1;
    cyc("ta_ack", ov(1, R_SID, 0, 1, 0));
    bus.sid_dtack = 1'b0; bus.FCS_n = 1'b1;
    cyc("ta_end", ov(0, R_NONE, 0, 0, 0));

    // FCS_n held low across an address change: only the first cycle decodes
    bus.ADDR = 16'h408C; bus.READ = 1'b1; bus.FCS_n = 1'b0;
    cyc("b2b_dec", ov(1, R_SID, 1, 0, 0));
    bus.sid_dtack = 1'b1;
    cyc("b2b_ack", ov(1, R_SID, 1, 1, 0));
    bus.sid_dtack = 1'b0; bus.ADDR = 16'h4080; bus.READ = 1'b0;
    cycn("b2b_hold", 3, ov(1, R_SID, 1, 1, 0));
    bus.FCS_n = 1'b1;
    cyc("b2b_gap", ov(0, R_NONE, 1, 0, 0));
    bus.FCS_n = 1'b0;
    cyc("b2b_dec2", ov(1, R_SCSI, 0, 0, 0));
    bus.FCS_n = 1'b1;
    cyc("b2b_end", ov(0, R_NONE, 0, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/z3_slave_decode.md
Name: z3_slave_decode

Overview:
- Zorro III slave-cycle front end for the A4092 card.
- Sits between the bus pins and the per-function responders (SCSI core, ID register, SID/DIP shadow).
- Latches the address on FCS_n assertion and publishes registered region selects plus slave_cycle.
- Merges the responders' DTACK requests into one bus DTACK, with a timeout fallback so a silent responder never hangs the bus.

Parameters:
- TIMEOUT_CYCLES, 64: CLK cycles from decode to forced termination; valid range 4..255.
- AUTOCFG_BASE, 8'hFF: ADDR[31:24] of autoconfig space while unconfigured.

Ports:
- CLK  in  1  system clock; FCS_n and ADDR are synchronous to it.
- RESET_n  in  1  asynchronous reset, active-low.
- FCS_n  in  1  Zorro III full cycle strobe, active-low.
- ADDR  in  16  bus address bits [31:16].
- READ  in  1  1 = read cycle; latched with the address.
- configured  in  1  board has been assigned a BAR.
- bar_base  in  8  assigned BAR, compared to ADDR[31:24].
- scsi_dtack, idreg_dtack, sid_dtack, autocfg_dtack  in  1 each  responder termination requests, active-high.
- slave_cycle  out  1  the current cycle targets this board.
- scsi_region, idreg_region, sidreg_region, autocfg_region  out  1 each  one-hot region selects.
- read_l  out  1  latched READ.
- dtack  out  1  drive bus DTACK (pad inverts).
- timeout_flag  out  1  sticky; set by forced termination.

Behaviour:
- Reset: all outputs 0 and state IDLE. Asynchronous assertion; outputs drop in the same instant even mid-cycle.
- Decode, evaluated combinationally on ADDR and registered only on cycle start:
  - autocfg: !configured && ADDR[31:24]==AUTOCFG_BASE.
  - In-BAR: configured && ADDR[31:24]==bar_base.
  - In-BAR with ADDR[23:18]==6'h20 or 6'h21: scsi (0x800000–0x87FFFF).
  - In-BAR with ADDR[23:18]==6'h22: idreg (0x880000–0x8BFFFF).
  - In-BAR with ADDR[23:18]==6'h23: sid (0x8C0000–0x8FFFFF).
  - Other in-BAR offsets: no region, slave_cycle=0, and the cycle is ignored.
- State machine:
  - IDLE: on a CLK edge with FCS_n=0, latch the region selects and read_l.
    - If any region matches, slave_cycle=1, clear the counter, go to ACTIVE.
    - Otherwise go to IGNORE.
  - ACTIVE: the counter increments each cycle.
    - If the selected region's dtack input is 1 (other regions' dtack inputs are ignored), dtack<=1 next edge and go to ACKED.
    - Else, if the counter reaches TIMEOUT_CYCLES-1, dtack<=1, timeout_flag<=1, go to ACKED.
    - If FCS_n=1 first (abort): clear the selects and slave_cycle, dtack stays 0, go to IDLE.
  - ACKED: dtack stays 1 until FCS_n=1. On that edge clear dtack, slave_cycle and the selects, go to IDLE.
  - IGNORE: wait for FCS_n=1, then go to IDLE. No outputs change.
- Latency:
  - Selects are valid 1 cycle after the FCS_n=0 sample.
  - dtack rises 1 cycle after the matching responder request.
  - Minimum cycle is 3 edges.
- ADDR and READ changes after latch are ignored until IDLE.
- FCS_n held low across back-to-back cycles: a new cycle starts only after a full IDLE pass, so each bus cycle requires FCS_n high for at least one edge.
- Simultaneous events:
  - Responder dtack on the timeout cycle: treated as a normal ack; timeout_flag not set.
  - FCS_n rising on the same edge as the responder ack: abort wins, dtack stays 0.
- timeout_flag clears only on reset.
- configured toggling mid-cycle has no effect until the next cycle start.

Decomposition:
- Shared package z3_pkg:
  - State encoding (IDLE, ACTIVE, ACKED, IGNORE).
  - Region offset constants: REG_SCSI_LO=6'h20, REG_SCSI_HI=6'h21, REG_IDREG=6'h22, REG_SID=6'h23.
  - AUTOCFG_BASE default.
- One sub-module, z3_region_decode: purely combinational address compare producing the one-hot region vector. Reused by the autoconfig block.

Test Plan:
- configured=1, bar_base=8'h40, ADDR=16'h408C, READ=1, FCS_n low; sid_dtack 3 cycles later -> sidreg_region=1 and slave_cycle=1 one cycle after FCS_n; dtack=1 one cycle after sid_dtack; all clear the edge after FCS_n rises.
- configured=0, ADDR=16'hFF00 -> autocfg_region=1; autocfg_dtack -> dtack. Repeat with configured=1, bar_base=8'h40, ADDR=16'hFF00 -> no selects, IGNORE, dtack never asserts.
- bar_base=8'h40, ADDR=16'h4088, no responder ack, TIMEOUT_CYCLES=64 -> dtack=1 and timeout_flag=1 on the 64th ACTIVE cycle; flag stays set after the cycle ends.
- In-BAR ADDR=16'h4080 (scsi region), scsi_dtack and FCS_n rising on the same edge -> dtack stays 0, return to IDLE. Second case: sid_dtack asserted while scsi selected -> ignored, timeout path taken.
- RESET_n pulsed low while in ACKED with dtack=1 -> dtack, slave_cycle and selects drop immediately; the next FCS_n cycle decodes normally.
- FCS_n held low across two address changes (16'h408C then 16'h4080) without going high -> only the first cycle is decoded; the second starts after FCS_n returns high.
